// File: rtl/ls_74283.sv
// 4-bit look-ahead-carry binary adder (74LS283 equivalent) with optional output register.
// Define LS_74283_OUT_REG_EN to register sum/cout/ovf; otherwise the _q outputs mirror the combinational path.
module ls_74283 (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       ovf,
    output logic [3:0] sum_q,
    output logic       cout_q,
    output logic       ovf_q
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign g[gi]   = a[gi] & b[gi];
            assign p[gi]   = a[gi] ^ b[gi];
            assign sum[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    // Every carry is a flat sum-of-products of g, p and cin; no carry feeds another.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign cout = c[4];
    assign ovf  = c[3] ^ c[4];

`ifdef LS_74283_OUT_REG_EN
    logic [3:0] sum_reg;
    logic       cout_reg;
    logic       ovf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg  <= 4'b0000;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (ce) begin
            sum_reg  <= sum;
            cout_reg <= cout;
            ovf_reg  <= ovf;
        end
    end

    assign sum_q  = sum_reg;
    assign cout_q = cout_reg;
    assign ovf_q  = ovf_reg;
`else
    // Register bypassed: clock, reset and enable are intentionally left dangling.
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, rst, ce};

    assign sum_q  = sum;
    assign cout_q = cout;
    assign ovf_q  = ovf;
`endif

endmodule

// File: tb/tb_ls_74283.sv
// Self-checking bench for ls_74283: directed, exhaustive and random vectors against an arithmetic model.
// Register-path checks are active when LS_74283_OUT_REG_EN is defined.
module tb_ls_74283;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ce  = 1'b0;
    logic [3:0] a   = 4'd0;
    logic [3:0] b   = 4'd0;
    logic       cin = 1'b0;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
    logic [3:0] sum_q;
    logic       cout_q;
    logic       ovf_q;

    int n_vec = 0;
    int n_err = 0;

    ls_74283 dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf),
        .sum_q  (sum_q),
        .cout_q (cout_q),
        .ovf_q  (ovf_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s a=%b b=%b cin=%b got=%b want=%b", tag, a, b, cin, obs, exp);
        end
    endtask

    // Reference: plain integer addition, overflow from the sign-bit rule.
    function automatic logic [5:0] ref_add(input logic [3:0] ra, input logic [3:0] rb,
                                           input logic rc);
        int   total;
        logic [3:0] s;
        logic v;
        total = int'(ra) + int'(rb) + int'(rc);
        s = total[3:0];
        v = (ra[3] == rb[3]) && (s[3] != ra[3]);
        return {v, (total > 15), s};
    endfunction

    task automatic apply(input string tag, input logic [3:0] va, input logic [3:0] vb,
                         input logic vc);
        logic [5:0] e;
        a = va; b = vb; cin = vc;
        #1;
        e = ref_add(va, vb, vc);
        check({tag, ".sum"},  {4'd0, sum},  {4'd0, e[3:0]});
        check({tag, ".cout"}, {7'd0, cout}, {7'd0, e[4]});
        check({tag, ".ovf"},  {7'd0, ovf},  {7'd0, e[5]});
`ifndef LS_74283_OUT_REG_EN
        check({tag, ".sum_q"}, {2'd0, ovf_q, cout_q, sum_q}, {2'd0, e});
`endif
    endtask

    initial begin
        logic [5:0] e;
        logic [5:0] q_exp;

        // Directed vectors from the datasheet-style cases.
        rst = 1'b1;
        #1;
`ifdef LS_74283_OUT_REG_EN
        check("rst_state", {2'd0, ovf_q, cout_q, sum_q}, 8'd0);
`endif
        apply("v1", 4'b1010, 4'b0101, 1'b0);
        #9;
        check("v1_settled", {4'd0, sum}, 8'b0000_1111);
        apply("v2", 4'b1111, 4'b0001, 1'b1);
        check("v2_sum", {3'd0, cout, sum}, 8'b0001_0001);
        apply("ovf_pos", 4'b0111, 4'b0001, 1'b0);
        check("ovf_pos_lit", {2'd0, ovf, cout, sum}, 8'b0010_1000);
        apply("ovf_neg", 4'b1000, 4'b1000, 1'b0);
        check("ovf_neg_lit", {2'd0, ovf, cout, sum}, 8'b0011_0000);

        // Exhaustive sweep (reset held so the register stays quiet in the registered build).
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            apply("sweep", v[8:5], v[4:1], v[0]);
        end

        for (int i = 0; i < 200; i++)
            apply("rand", 4'($urandom), 4'($urandom), 1'($urandom));

`ifdef LS_74283_OUT_REG_EN
        @(negedge clk);
        rst = 1'b0;
        a = 4'b0011; b = 4'b0100; cin = 1'b1; ce = 1'b1;
        @(posedge clk); #1;
        check("reg_load", {2'd0, ovf_q, cout_q, sum_q}, 8'b0010_1000);
        ce = 1'b0; a = 4'b0101; b = 4'b0110; cin = 1'b0;
        @(posedge clk); #1;
        check("reg_hold", {2'd0, ovf_q, cout_q, sum_q}, 8'b0010_1000);

        // Mid-cycle asynchronous reset.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", {2'd0, ovf_q, cout_q, sum_q}, 8'd0);
        e = ref_add(a, b, cin);
        check("comb_in_rst", {2'd0, ovf, cout, sum}, {2'd0, e});
        ce = 1'b1;
        @(posedge clk); #1;
        check("rst_over_edge", {2'd0, ovf_q, cout_q, sum_q}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_release", {2'd0, ovf_q, cout_q, sum_q}, {2'd0, ref_add(a, b, cin)});

        // Random enable pattern with a one-entry register model.
        q_exp = ref_add(a, b, cin);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom); ce = 1'($urandom);
            if (ce) q_exp = ref_add(a, b, cin);
            @(posedge clk); #1;
            check("reg_rand", {2'd0, ovf_q, cout_q, sum_q}, {2'd0, q_exp});
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ls_74283.md
# ls_74283

4-bit binary full adder with fast (look-ahead) carry, functionally equivalent to the 74LS283 part, used as the arithmetic building block in the CPU datapath (ALU slices, PC incrementer). The adder path is purely combinational. An optional pipeline register captures sum, carry and flags on the clock for timing-closure use in the datapath.

## Interface
- No parameters; width fixed at 4 bits.
- `clk`  in  1  system clock; used only by the output register.
- `rst`  in  1  reset, asynchronous and active-high; clears the output register.
- `ce`  in  1  clock enable for the output register.
- `a`  in  4  addend A.
- `b`  in  4  addend B.
- `cin`  in  1  carry in (C0).
- `sum`  out  4  combinational sum, `a + b + cin` modulo 16.
- `cout`  out  1  combinational carry out (C4).
- `ovf`  out  1  combinational two's-complement overflow.
- `sum_q`  out  4  registered sum.
- `cout_q`  out  1  registered carry out.
- `ovf_q`  out  1  registered overflow.

## Operation
- Per bit i:
  - generate: g[i] = a[i] & b[i]
  - propagate: p[i] = a[i] ^ b[i]
- Carries computed by two-level look-ahead from g, p and cin. No ripple chain.
  - c1 = g0 | p0·cin
  - c2 = g1 | p1·g0 | p1·p0·cin
  - c3 and c4 follow the same pattern.
- Outputs:
  - sum[i] = p[i] ^ c[i], with c0 = cin.
  - cout = c4.
- `{cout,sum}` must equal the 5-bit value a+b+cin for all 512 input combinations.
- ovf = c3 ^ c4. It is set when a and b have equal sign bits and sum[3] differs from them.
- Wrap-around: sum is taken modulo 16. Example: 1111+0001+1 gives sum 0001, cout 1.
- No X-propagation special cases. Any X or Z on an input may yield X outputs.

## Timing
- `sum`, `cout`, `ovf`: zero latency. They settle within the same delta/propagation time as input changes and need no clock.
- Registered outputs `sum_q`, `cout_q`, `ovf_q`:
  - On the rising edge of `clk` with `ce`=1, they load the current combinational sum, cout and ovf.
  - With `ce`=0 they hold their value.
- Latency of the registered path: 1 cycle.
- Reset:
  - `rst`=1 clears `sum_q`=0000, `cout_q`=0, `ovf_q`=0 immediately, without waiting for a clock edge.
  - Asserting `rst` mid-cycle clears the register at once.
  - While `rst` is high, clock edges are ignored, including edges with `ce`=1.
  - Loading resumes on the first rising edge after deassertion.
- The combinational outputs are unaffected by `rst` and `ce`.

## Configuration
- Macro `LS_74283_OUT_REG_EN`.
- Defined: output register implemented as described in Timing.
- Undefined:
  - No flip-flops are instantiated.
  - `sum_q`, `cout_q` and `ovf_q` are driven combinationally, equal to `sum`, `cout` and `ovf`.
  - `clk`, `rst` and `ce` are unused.
- Port list is identical in both builds.

## Test plan
- Vector 1: a=1010, b=0101, cin=0, wait 10 ns → sum=1111, cout=0, ovf=0.
- Vector 2: a=1111, b=0001, cin=1 → sum=0001, cout=1, ovf=0.
- Signed overflow: a=0111, b=0001, cin=0 → sum=1000, cout=0, ovf=1. Then a=1000, b=1000, cin=0 → sum=0000, cout=1, ovf=1.
- Exhaustive sweep of all 512 (a,b,cin) combinations without a clock → `{cout,sum}` equals a+b+cin in every case; ovf matches the sign rule in every case.
- Register path (macro defined):
  - Rising edge with a=0011, b=0100, cin=1, ce=1 → sum_q=1000, ovf_q=1, cout_q=0 after the edge.
  - Then drive ce=0 and change the inputs → sum_q holds 1000.
- Async reset (macro defined): with sum_q nonzero, raise rst between clock edges → sum_q, cout_q and ovf_q are 0 before the next edge. Hold rst across an edge with ce=1 → outputs stay 0.
